note_sequencer: RTL and testbench
=================================

# note_sequencer

Parametrised note-sequence recorder and player for the piezo path. It stores up to DEPTH notes of NOTE_W bits written by index, exposes any stored note for display, and plays a programmed range (index 0 through a latched last index) at a fixed step rate. Playback can be one-shot or looping, can be aborted, and signals completion. It sits between the keypad/answer-entry logic and the piezo tone generator.

## Interface
- NOTE_W, 4, bits per note code; code 0 is a rest.
- DEPTH, 16, number of note slots; must be a power of two, at least 2.
- IDX_W, $clog2(DEPTH), index width (derived).
- TICK_DIV, 5_000_000, clk cycles each note is held; at least 2.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write wr_note into slot wr_idx this cycle.
- wr_idx  in  IDX_W  write slot.
- wr_note  in  NOTE_W  write data.
- rd_idx  in  IDX_W  display read slot.
- rd_note  out  NOTE_W  registered contents of slot rd_idx.
- last_idx  in  IDX_W  index of the final note to play; sampled on play start.
- loop_en  in  1  sampled continuously; on the final step, 1 wraps to slot 0 and 0 ends playback.
- play  in  1  start playback (level or pulse; acted on only in IDLE).
- stop  in  1  abort playback.
- note_out  out  NOTE_W  note code currently being played; 0 when idle.
- note_valid  out  1  note_out is a played note.
- playing  out  1  FSM is in PLAY.
- play_idx  out  IDX_W  slot currently on note_out.
- done  out  1  one-cycle pulse on natural completion.

## Operation
- Storage: DEPTH x NOTE_W register array, cleared to 0 on reset. wr_en writes on the clock edge in any state.
- rd_note <= mem[rd_idx] every cycle. Write and read of the same slot in the same cycle returns the old value; the new value appears one cycle later.
- FSM states: IDLE, PLAY.
  - IDLE, play=1 and stop=0: last_reg <= last_idx, play_idx <= 0, note_out <= mem[0], note_valid <= 1, tick counter cleared; go to PLAY.
  - PLAY, stop=1: go to IDLE, note_out <= 0, note_valid <= 0, play_idx <= 0. No done pulse.
  - PLAY, step tick with play_idx < last_reg: play_idx+1, note_out <= mem[play_idx+1].
  - PLAY, step tick with play_idx == last_reg and loop_en=1: play_idx <= 0, note_out <= mem[0].
  - PLAY, step tick with play_idx == last_reg and loop_en=0: go to IDLE, done <= 1 for one cycle, outputs cleared as for stop.
- play while in PLAY is ignored. Changes to last_idx during PLAY are ignored.
- stop and play both asserted in IDLE: stop wins, and the FSM stays in IDLE.
- stop coinciding with the final tick: stop wins, and no done pulse is issued.
- A write to a slot during PLAY does not change the note_out already latched. The new value is used when that slot is next stepped to.
- last_idx = 0 plays a single note.

## Timing
- Reset values: rd_note=0, note_out=0, note_valid=0, playing=0, play_idx=0, done=0, tick counter=0, state IDLE.
- Start latency: play is sampled at edge N, and note_out, playing and note_valid are valid after edge N.
- Each note is held exactly TICK_DIV cycles. The tick counter counts 0..TICK_DIV-1 and asserts a step when it is TICK_DIV-1.
- One-shot duration: playing is high for (last_reg+1)*TICK_DIV cycles. done is high in the first cycle after playing falls.
- stop takes effect at the next edge (one-cycle latency). The counter is inactive in IDLE.

## Structure
- Shared package note_pkg holds:
  - the state enum {IDLE, PLAY};
  - NOTE_REST = '0;
  - the default TICK_DIV constant, shared with the tone generator.
- Sub-module tick_divider (parameter DIV) provides clr, en and a one-cycle tick output. It is instantiated once, with clr driven on play start and on stop.
- Everything else, including the memory, the FSM and the output registers, stays in note_sequencer.

## Test plan
All scenarios use TICK_DIV=4 and DEPTH=8.
- Reset mid-playback → all outputs 0 on the same cycle, and every slot reads 0 through rd_note.
- Write slots 0..2 = 3,5,7; last_idx=2; loop_en=0; pulse play → note_out 3,5,7, each for 4 cycles. playing is high for 12 cycles, then done pulses for one cycle, then note_out=0.
- Same program with loop_en=1 → sequence 3,5,7,3,5,… with no done pulse. Clearing loop_en while slot 1 plays → stops after 7, then done.
- stop asserted 6 cycles into playback → IDLE after the next edge, note_out=0, no done. A later play restarts from slot 0.
- Write slot 2=9 while slot 1 plays → slot 2 plays 9. A same-cycle write and read of slot 4 shows the old value, then 9 on the following cycle.
- play and stop asserted together in IDLE → remains IDLE. last_idx=0 → single note for 4 cycles, then done.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the piezo note path: FSM states, rest code and
// the default step rate also used by the tone generator.
package note_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   // Wide constant; users slice it to their note width.
   localparam logic [31:0] NOTE_REST = '0;

   localparam int DEFAULT_TICK_DIV = 5_000_000;

endpackage

// File: rtl/tick_divider.sv
// Step-rate divider: counts 0..DIV-1 while enabled and pulses tick for one
// cycle on the final count. clr restarts the count from 0.
module tick_divider
   import note_pkg::*;
#(
   parameter int DIV = DEFAULT_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = en && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Note-sequence recorder/player: indexed note storage with a display read
// port, and a one-shot or looping player stepping at the tick_divider rate.
module note_sequencer
   import note_pkg::*;
#(
   parameter int NOTE_W   = 4,
   parameter int DEPTH    = 16,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [NOTE_W-1:0] wr_note,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [NOTE_W-1:0] rd_note,
   input  logic [IDX_W-1:0]  last_idx,
   input  logic              loop_en,
   input  logic              play,
   input  logic              stop,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic              playing,
   output logic [IDX_W-1:0]  play_idx,
   output logic              done
);

   localparam logic [NOTE_W-1:0] REST = NOTE_REST[NOTE_W-1:0];

   logic [NOTE_W-1:0] mem [DEPTH];
   state_t            state;
   logic [IDX_W-1:0]  last_reg;
   logic              start;
   logic              tick;

   assign start   = (state == IDLE) && play && !stop;
   assign playing = (state == PLAY);

   tick_divider #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (start || stop),
      .en    (state == PLAY),
      .tick  (tick)
   );

   // Writes land in any state; an already latched note_out is unaffected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= REST;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_note;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_note <= REST;
      end else begin
         rd_note <= mem[rd_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_reg   <= '0;
         play_idx   <= '0;
         note_out   <= REST;
         note_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= PLAY;
                  last_reg   <= last_idx;
                  play_idx   <= '0;
                  note_out   <= mem[0];
                  note_valid <= 1'b1;
               end
            end
            PLAY: begin
               // stop outranks the final tick, so an abort never pulses done.
               if (stop) begin
                  state      <= IDLE;
                  play_idx   <= '0;
                  note_out   <= REST;
                  note_valid <= 1'b0;
               end else if (tick) begin
                  if (play_idx < last_reg) begin
                     play_idx <= play_idx + 1'b1;
                     note_out <= mem[play_idx + 1'b1];
                  end else if (loop_en) begin
                     play_idx <= '0;
                     note_out <= mem[0];
                  end else begin
                     state      <= IDLE;
                     play_idx   <= '0;
                     note_out   <= REST;
                     note_valid <= 1'b0;
                     done       <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a per-cycle scoreboard of
// {play_idx, note_out} expectations for every cycle the player is active.
module tb_note_sequencer;

   localparam int NOTE_W = 4;
   localparam int DEPTH  = 8;
   localparam int IDX_W  = 3;
   localparam int TDIV   = 4;
   localparam int W      = IDX_W + NOTE_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic [IDX_W-1:0]  wr_idx = '0;
   logic [NOTE_W-1:0] wr_note = '0;
   logic [IDX_W-1:0]  rd_idx = '0;
   logic [NOTE_W-1:0] rd_note;
   logic [IDX_W-1:0]  last_idx = '0;
   logic              loop_en = 1'b0;
   logic              play = 1'b0;
   logic              stop = 1'b0;
   logic [NOTE_W-1:0] note_out;
   logic              note_valid;
   logic              playing;
   logic [IDX_W-1:0]  play_idx;
   logic              done;

   logic [W-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;
   int pcount;
   int done_seen;

   note_sequencer #(
      .NOTE_W(NOTE_W), .DEPTH(DEPTH), .TICK_DIV(TDIV)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_note(wr_note),
      .rd_idx(rd_idx), .rd_note(rd_note),
      .last_idx(last_idx), .loop_en(loop_en), .play(play), .stop(stop),
      .note_out(note_out), .note_valid(note_valid), .playing(playing),
      .play_idx(play_idx), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_slot(input int idx, input int note);
      wr_en = 1'b1;
      wr_idx = IDX_W'(idx);
      wr_note = NOTE_W'(note);
      step();
      wr_en = 1'b0;
   endtask

   // Each note is expected for TDIV consecutive cycles.
   task automatic push_note(input int idx, input int note, input int cycles);
      for (int k = 0; k < cycles; k++) exp_q.push_back({IDX_W'(idx), NOTE_W'(note)});
   endtask

   task automatic start_play();
      play = 1'b1;
      step();
      play = 1'b0;
   endtask

   // Samples every cycle until playing drops; optional actions at given cycle counts.
   task automatic watch(input int budget, input int stop_at, input int loop_clr_at,
                        input int wr_at, output int pc, output int ds);
      logic [W-1:0] e;
      bit ended;
      pc = 0;
      ds = 0;
      ended = 0;
      for (int c = 0; c < budget && !ended; c++) begin
         if (playing) begin
            pc++;
            if (done) ds++;
            if (exp_q.size() == 0) begin
               check("note_underflow", 32'(exp_q.size()), 1);
            end else begin
               e = exp_q.pop_front();
               check("idx_note", {play_idx, note_out}, e);
            end
            check("note_valid", note_valid, 1);
            if (pc == stop_at) stop = 1'b1;
            if (pc == loop_clr_at) loop_en = 1'b0;
            if (pc == wr_at) begin
               wr_en = 1'b1; wr_idx = 3'd2; wr_note = 4'd9;
            end
            step();
            stop = 1'b0;
            wr_en = 1'b0;
         end else begin
            ended = 1;
            if (done) ds++;
            check("idle_note_out", note_out, 0);
            check("idle_note_valid", note_valid, 0);
            check("idle_play_idx", play_idx, 0);
         end
      end
      if (!ended) check("watch_timeout", 0, 1);
      check("queue_drained", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   initial begin
      // reset state
      #12;
      check("rst_rd_note", rd_note, 0);
      check("rst_note_out", note_out, 0);
      check("rst_note_valid", note_valid, 0);
      check("rst_playing", playing, 0);
      check("rst_play_idx", play_idx, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      step();

      write_slot(0, 3);
      write_slot(1, 5);
      write_slot(2, 7);
      for (int i = 0; i < 3; i++) begin
         rd_idx = 3'(i);
         step();
         check("readback", rd_note, (i == 0) ? 3 : (i == 1) ? 5 : 7);
      end

      // one-shot 3,5,7; last_idx change during play must be ignored
      last_idx = 3'd2;
      loop_en = 1'b0;
      push_note(0, 3, TDIV); push_note(1, 5, TDIV); push_note(2, 7, TDIV);
      start_play();
      last_idx = 3'd5;
      watch(40, 0, 0, 0, pcount, done_seen);
      check("oneshot_len", pcount, 12);
      check("oneshot_done", done_seen, 1);
      step();
      check("done_one_cycle", done, 0);
      last_idx = 3'd2;

      // looping, loop_en cleared while slot 1 plays the second time
      loop_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         push_note(0, 3, TDIV); push_note(1, 5, TDIV); push_note(2, 7, TDIV);
      end
      start_play();
      watch(60, 0, 18, 0, pcount, done_seen);
      check("loop_len", pcount, 24);
      check("loop_done", done_seen, 1);
      step();

      // stop 6 cycles in, then restart from slot 0
      push_note(0, 3, TDIV); push_note(1, 5, 2);
      start_play();
      watch(40, 6, 0, 0, pcount, done_seen);
      check("stop_len", pcount, 6);
      check("stop_no_done", done_seen, 0);
      step();
      check("stop_no_done_late", done, 0);
      push_note(0, 3, TDIV); push_note(1, 5, TDIV); push_note(2, 7, TDIV);
      start_play();
      watch(40, 0, 0, 0, pcount, done_seen);
      check("restart_len", pcount, 12);
      check("restart_done", done_seen, 1);
      step();

      // write slot 2 = 9 while slot 1 plays
      push_note(0, 3, TDIV); push_note(1, 5, TDIV); push_note(2, 9, TDIV);
      start_play();
      watch(40, 0, 0, 5, pcount, done_seen);
      check("wr_play_len", pcount, 12);
      step();

      // same-cycle write/read of slot 4
      rd_idx = 3'd4;
      step();
      check("rd4_before", rd_note, 0);
      wr_en = 1'b1; wr_idx = 3'd4; wr_note = 4'd9;
      step();
      wr_en = 1'b0;
      check("rd4_same_cycle", rd_note, 0);
      step();
      check("rd4_next_cycle", rd_note, 9);

      // play and stop together in IDLE
      play = 1'b1; stop = 1'b1;
      step();
      play = 1'b0; stop = 1'b0;
      check("play_stop_playing", playing, 0);
      check("play_stop_valid", note_valid, 0);
      step();
      check("play_stop_still_idle", playing, 0);

      // single note
      last_idx = 3'd0;
      push_note(0, 3, TDIV);
      start_play();
      watch(20, 0, 0, 0, pcount, done_seen);
      check("single_len", pcount, 4);
      check("single_done", done_seen, 1);
      step();

      // reset mid-playback clears outputs asynchronously and wipes memory
      last_idx = 3'd2;
      rd_idx = 3'd1;
      start_play();
      repeat (5) @(posedge clk);
      #3;
      check("pre_reset_playing", playing, 1);
      reset = 1'b1;
      #1;
      check("arst_note_out", note_out, 0);
      check("arst_note_valid", note_valid, 0);
      check("arst_playing", playing, 0);
      check("arst_play_idx", play_idx, 0);
      check("arst_rd_note", rd_note, 0);
      step();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = 3'(i);
         step();
         check("arst_mem", rd_note, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
